// File: rtl/ps2_key_event_decoder.sv
// PS/2 keyboard receiver: synchronises the line, checks frames, decodes E0/F0 prefixes
// into make/break events in a FIFO and tracks held direction keys.
module ps2_key_event_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8,
  parameter int ACCEPT_KEYPAD  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clk,
  input  logic       key_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [9:0] evt_data,
  output logic       kup,
  output logic       kdown,
  output logic       kleft,
  output logic       kright,
  output logic       dir_pulse,
  output logic [1:0] dir_code,
  output logic       frame_err,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   prev_clk;
  logic                   ps_clk, ps_dat, fe;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      prev_clk <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], key_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], key_data};
      prev_clk <= ps_clk;
    end
  end

  assign ps_clk = clk_sync[SYNC_STAGES-1];
  assign ps_dat = dat_sync[SYNC_STAGES-1];
  assign fe     = prev_clk & ~ps_clk;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_ok;
  logic [TW-1:0] tcnt;
  logic          byte_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      parity_ok  <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fe) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!ps_dat) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {ps_dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_ok <= ^{shreg, ps_dat};
            state     <= STOP;
          end
          STOP: begin
            if (ps_dat && parity_ok) byte_valid <= 1'b1;
            else                     frame_err  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A stalled frame is abandoned so a later clean frame can resync.
        if (tcnt == T_LAST) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + T_ONE;
        end
      end
    end
  end

  logic       ext, brk;
  logic       ev_wr;
  logic [9:0] ev_dat;
  logic       pad_code, wasd_code;
  logic [1:0] dsel;
  logic       arrow_hit, wasd_hit, kp_hit;

  always_comb begin
    ev_wr     = byte_valid && (shreg != 8'hE0) && (shreg != 8'hF0);
    ev_dat    = {brk, ext, shreg};
    pad_code  = 1'b0;
    wasd_code = 1'b0;
    dsel      = 2'd0;
    case (shreg)
      8'h75: begin pad_code  = 1'b1; dsel = 2'd0; end
      8'h72: begin pad_code  = 1'b1; dsel = 2'd1; end
      8'h6B: begin pad_code  = 1'b1; dsel = 2'd2; end
      8'h74: begin pad_code  = 1'b1; dsel = 2'd3; end
      8'h1D: begin wasd_code = 1'b1; dsel = 2'd0; end
      8'h1B: begin wasd_code = 1'b1; dsel = 2'd1; end
      8'h1C: begin wasd_code = 1'b1; dsel = 2'd2; end
      8'h23: begin wasd_code = 1'b1; dsel = 2'd3; end
      default: ;
    endcase
    arrow_hit = ev_wr & ext & pad_code;
    wasd_hit  = ev_wr & ~ext & wasd_code;
    kp_hit    = ev_wr & ~ext & pad_code & (ACCEPT_KEYPAD != 0);
  end

  // Each key source is held separately so releasing W does not drop a held up-arrow.
  logic [3:0] held_arrow, held_wasd, held_kp;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      held_arrow <= 4'd0;
      held_wasd  <= 4'd0;
      held_kp    <= 4'd0;
      dir_pulse  <= 1'b0;
      dir_code   <= 2'd0;
    end else begin
      dir_pulse <= 1'b0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (shreg == 8'hE0)      ext <= 1'b1;
        else if (shreg == 8'hF0) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
      if (arrow_hit) held_arrow[dsel] <= ~brk;
      if (wasd_hit)  held_wasd[dsel]  <= ~brk;
      if (kp_hit)    held_kp[dsel]    <= ~brk;
      if ((arrow_hit | wasd_hit | kp_hit) && !brk) begin
        dir_pulse <= 1'b1;
        dir_code  <= dsel;
      end
    end
  end

  assign kup    = held_arrow[0] | held_wasd[0] | held_kp[0];
  assign kdown  = held_arrow[1] | held_wasd[1] | held_kp[1];
  assign kleft  = held_arrow[2] | held_wasd[2] | held_kp[2];
  assign kright = held_arrow[3] | held_wasd[3] | held_kp[3];

  logic [9:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = evt_valid & evt_ready;
  assign push  = ev_wr & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (ev_wr && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)          overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ev_dat;
  end

  assign evt_valid = ~empty;
  assign evt_data  = evt_valid ? mem[rd_ptr[AW-1:0]] : 10'd0;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench: PS/2 frames driven bit by bit, outputs checked against hand-derived values.
module tb_ps2_key_event_decoder;

  localparam int HALF = 8;
  localparam int TOUT = 200;

  logic clk = 1'b0;
  logic rst, key_clk, key_data, evt_ready, ovf_clr;

  logic       evt_valid, kup, kdown, kleft, kright, dir_pulse, frame_err, overflow;
  logic [9:0] evt_data;
  logic [1:0] dir_code;

  logic       kp_valid, kp_kup, kp_kdown, kp_kleft, kp_kright, kp_pulse, kp_err, kp_ovf;
  logic [9:0] kp_data;
  logic [1:0] kp_code;

  int compared   = 0;
  int mismatched = 0;

  logic       c3_err, c3_vld, c4_err, c4_vld, c4_pulse, c5_pulse;
  logic [9:0] c4_dat;
  logic [1:0] c4_code;

  always #5 clk = ~clk;

  ps2_key_event_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TOUT), .FIFO_DEPTH(8), .ACCEPT_KEYPAD(0)) dut (
    .clk(clk), .rst(rst), .key_clk(key_clk), .key_data(key_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .kup(kup), .kdown(kdown), .kleft(kleft), .kright(kright),
    .dir_pulse(dir_pulse), .dir_code(dir_code), .frame_err(frame_err),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  ps2_key_event_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TOUT), .FIFO_DEPTH(8), .ACCEPT_KEYPAD(1)) dut_kp (
    .clk(clk), .rst(rst), .key_clk(key_clk), .key_data(key_data),
    .evt_valid(kp_valid), .evt_ready(evt_ready), .evt_data(kp_data),
    .kup(kp_kup), .kdown(kp_kdown), .kleft(kp_kleft), .kright(kp_kright),
    .dir_pulse(kp_pulse), .dir_code(kp_code), .frame_err(kp_err),
    .overflow(kp_ovf), .ovf_clr(ovf_clr)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Captures land on the 3rd/4th/5th clk negedge after the PS/2 falling edge,
  // i.e. cycles N+1, N+2, N+3 relative to the fe-detect cycle N.
  task automatic ps2_bit(input logic b);
    @(negedge clk);
    key_data = b;
    repeat (HALF) @(negedge clk);
    key_clk = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      if (i == 3) begin c3_err = frame_err; c3_vld = evt_valid; end
      if (i == 4) begin
        c4_err = frame_err; c4_vld = evt_valid; c4_dat = evt_data;
        c4_pulse = dir_pulse; c4_code = dir_code;
      end
      if (i == 5) c5_pulse = dir_pulse;
    end
    key_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk); evt_ready = 1'b1;
    @(negedge clk); evt_ready = 1'b0;
  endtask

  initial begin
    int  seen_at;
    rst = 1'b1; key_clk = 1'b1; key_data = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_evt_valid", 16'(evt_valid), 16'h0);
    check("rst_evt_data",  16'(evt_data),  16'h0);
    check("rst_dirs",      16'({kup, kdown, kleft, kright}), 16'h0);
    check("rst_dir_pulse", 16'(dir_pulse), 16'h0);
    check("rst_dir_code",  16'(dir_code),  16'h0);
    check("rst_frame_err", 16'(frame_err), 16'h0);
    check("rst_overflow",  16'(overflow),  16'h0);

    // W make: event at N+2, one-cycle dir_pulse
    send_frame(8'h1D, 1'b0);
    check("w_valid_n1",  16'(c3_vld),   16'h0);
    check("w_valid_n2",  16'(c4_vld),   16'h1);
    check("w_data_n2",   16'(c4_dat),   16'h01D);
    check("w_pulse_n2",  16'(c4_pulse), 16'h1);
    check("w_code_n2",   16'(c4_code),  16'h0);
    check("w_pulse_n3",  16'(c5_pulse), 16'h0);
    check("w_kup",       16'(kup),      16'h1);
    pop_one();
    check("w_popped",    16'(evt_valid), 16'h0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    check("w_brk_data",  16'(evt_data), 16'h21D);
    check("w_brk_kup",   16'(kup),      16'h0);
    pop_one();

    // extended right arrow make then break
    send_frame(8'hE0, 1'b0);
    send_frame(8'h74, 1'b0);
    check("rt_make_data", 16'(evt_data), 16'h174);
    check("rt_make_kr",   16'(kright),   16'h1);
    check("rt_code",      16'(dir_code), 16'h3);
    pop_one();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h74, 1'b0);
    check("rt_brk_data",  16'(evt_data), 16'h374);
    check("rt_brk_kr",    16'(kright),   16'h0);
    pop_one();

    // parity error after E0 clears the prefix
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b1);
    check("par_err_n1",   16'(c3_err), 16'h1);
    check("par_err_n2",   16'(c4_err), 16'h0);
    check("par_no_evt",   16'(c4_vld), 16'h0);
    check("par_kleft",    16'(kleft),  16'h0);
    send_frame(8'h74, 1'b0);
    check("par_next_data", 16'(evt_data), 16'h074);
    check("par_next_kr",   16'(kright),   16'h0);
    pop_one();

    // start bit plus 4 data bits, then silence
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    seen_at = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (frame_err && seen_at < 0) seen_at = i;
    end
    check("tout_seen",   16'(seen_at > 0), 16'h1);
    check("tout_window", 16'(seen_at >= 185 && seen_at <= 205), 16'h1);
    check("tout_no_evt", 16'(evt_valid), 16'h0);
    send_frame(8'h23, 1'b0);
    check("tout_next_data", 16'(evt_data), 16'h023);
    check("tout_next_kr",   16'(kright),   16'h1);
    pop_one();

    // nine makes into an eight-entry FIFO
    for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b0);
    check("ovf_set",    16'(overflow), 16'h1);
    check("ovf_head",   16'(evt_data), 16'h010);
    @(negedge clk);
    check("ovf_stable", 16'(evt_data), 16'h010);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", 16'(overflow), 16'h0);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 16'(evt_valid), 16'h1);
      check("drain_data",  16'(evt_data),  16'(10'h010 + 10'(i)));
      @(negedge clk);
    end
    check("drain_empty", 16'(evt_valid), 16'h0);
    evt_ready = 1'b0;

    // keypad 8 (non-extended 75)
    send_frame(8'h75, 1'b0);
    check("kp0_data", 16'(evt_data), 16'h075);
    check("kp0_kup",  16'(kup),      16'h0);
    check("kp1_kup",  16'(kp_kup),   16'h1);
    pop_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
Parametrised PS/2 keyboard receiver and scancode decoder for the snake game and follow-on projects. It synchronises the PS/2 clock and data lines and receives 11-bit frames with start, parity and stop checking plus a frame timeout. It decodes the E0 (extended) and F0 (break) prefixes into make/break key events, buffers those events in a FIFO with a valid/ready interface, and keeps held-state direction outputs for arrow and WASD keys.

Parameters:
SYNC_STAGES, 2, flip-flop stages on key_clk and key_data; legal values are 2 to 4
TIMEOUT_CYCLES, 100000, clk cycles allowed between PS/2 falling edges inside a frame before the frame is aborted
FIFO_DEPTH, 8, number of event FIFO entries; must be a power of 2, from 2 to 64
ACCEPT_KEYPAD, 0, when 1, non-extended keypad codes 75/72/6B/74 also drive the direction outputs

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
key_clk  in  1  PS/2 clock, asynchronous, idles at 1
key_data  in  1  PS/2 data, asynchronous, idles at 1
evt_valid  out  1  FIFO head holds a valid event
evt_ready  in  1  consumer accepts the head event; a pop happens when evt_valid and evt_ready are both 1
evt_data  out  10  {brk, ext, code[7:0]} of the FIFO head
kup, kdown, kleft, kright  out  1  level, high while a mapped key is held
dir_pulse  out  1  one-cycle pulse on each make of a mapped direction key
dir_code  out  2  direction of the latest dir_pulse: 0=up, 1=down, 2=left, 3=right; holds its value between pulses
frame_err  out  1  one-cycle pulse on a start, parity, stop or timeout error
overflow  out  1  sticky; set when an event is dropped because the FIFO is full
ovf_clr  in  1  clears overflow; a set in the same cycle wins

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets all of the following:
  - synchroniser flops to 1
  - receiver to IDLE, prefix flags to 0, FIFO empty
  - all outputs to 0
- PS/2 falling edge (fe): previous synchronised clk=1 and current=0. Data is sampled from the final synchroniser stage in the same cycle.
- Receiver FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe with data=0, go to DATA with bit count 0. On fe with data=1, pulse frame_err and stay in IDLE.
  - DATA: shift in on each fe, LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fe, record parity_ok = (XOR of the 8 data bits and the parity bit) == 1, i.e. odd parity. Go to STOP.
  - STOP: on fe, if data=1 and parity_ok, raise byte_valid for one cycle (cycle N+1, where N is the stop-bit fe cycle). Otherwise pulse frame_err. Go to IDLE either way.
- Timeout: a counter clears on every fe and runs whenever the state is not IDLE. When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse frame_err, discard the partial byte.
- Any frame_err clears both prefix flags.
- Decoder, on byte_valid:
  - E0 sets ext.
  - F0 sets brk.
  - Any other byte B produces event {brk, ext, B} and clears both flags.
  - A repeated prefix (e.g. E0 E0) simply leaves its flag set.
- Event timing: the event is written to the FIFO at the end of cycle N+1.
  - With an empty FIFO, evt_valid=1 in cycle N+2. There is no combinational bypass.
  - Held outputs, dir_pulse and dir_code update in cycle N+2, independent of FIFO state.
- FIFO behaviour:
  - evt_data is stable while evt_valid=1 and evt_ready=0.
  - Full with a write and no pop: the new event is dropped and overflow is set. The held outputs still update.
  - Full with a write and a simultaneous pop: both happen, no overflow.
  - Empty with evt_ready=1: no pop, no underflow.
- Direction map (make sets the held bit, break clears it):
  - up: ext 75, or W (1D, non-ext)
  - down: ext 72, or S (1B)
  - left: ext 6B, or A (1C)
  - right: ext 74, or D (23)
  - If ACCEPT_KEYPAD=1, non-ext 75/72/6B/74 also map to up/down/left/right. If ACCEPT_KEYPAD=0, those codes produce FIFO events only.
  - Each direction output is the OR of its held sources.
- Typematic repeat makes re-pulse dir_pulse; the held state stays 1.
- Reset mid-frame: the receiver returns to IDLE. The next valid frame decodes normally.

Test Plan:
- Single byte 1D with correct parity: evt_data=0x01D (brk=0, ext=0) and evt_valid at N+2; kup=1; dir_pulse for one cycle with dir_code=0.
- E0 F0 74 after an E0 74 make: events 0x174 then 0x374; kright goes 1, then returns to 0 after the break.
- Parity bit inverted on byte 1C: frame_err pulses for one cycle; no event; kleft stays 0; prefix flags clear (a following 74 yields 0x074).
- Start bit then 4 bits, then no edges for TIMEOUT_CYCLES: frame_err pulses and the FSM is in IDLE; a following clean 23 gives event 0x023 and kright=1.
- FIFO_DEPTH=8 with evt_ready=0 and 9 makes: 8 events retained in order, overflow=1; ovf_clr clears it; with evt_ready=1 the events drain one per cycle.
- Non-ext 75 with ACCEPT_KEYPAD=0: event 0x075, kup stays 0. Same stimulus with ACCEPT_KEYPAD=1: kup=1.
